// File: rtl/assign_update.sv
// Forward assignment sweep: applies one variable assignment to every active clause in the
// clause RAM, writing back updated open/active bits and streaming out unit clauses.
module assign_update #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned NUM_CLAUSES = 256,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  output logic                 start_ready_o,
  input  logic [WIDTH-2:0]     asg_var_i,
  input  logic                 asg_val_i,
  output logic                 mem_rd_en_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic [3*WIDTH+4:0]   mem_rd_data_i,
  output logic                 mem_wr_en_o,
  output logic [3*WIDTH+4:0]   mem_wr_data_o,
  output logic                 unit_valid_o,
  input  logic                 unit_ready_i,
  output logic [WIDTH-1:0]     unit_lit_o,
  output logic [ADDR_W-1:0]    unit_idx_o,
  output logic                 done_o,
  output logic                 conflict_o,
  output logic [ADDR_W-1:0]    conflict_idx_o
);

  localparam int unsigned WordW = 3 * WIDTH + 5;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_CLAUSES - 1);

  typedef enum logic [2:0] {StIdle, StRd, StEval, StEmit, StWr, StNext, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [WIDTH-2:0]  var_q;
  logic              val_q;
  logic              conflict_q;

  logic [WIDTH-1:0]  lit [3];
  logic [WIDTH-1:0]  mag [3];
  logic [2:0]        rd_open, eq, pol, open_new;
  logic              rd_valid, rd_active, hit, sat;
  logic [1:0]        open_cnt;
  logic [WIDTH-1:0]  unit_lit;
  logic [WordW-1:0]  upd_word;

  always_comb begin
    rd_valid  = mem_rd_data_i[WordW-1];
    rd_active = mem_rd_data_i[WordW-2];
    rd_open   = mem_rd_data_i[3*WIDTH+2 -: 3];
    eq        = '0;
    pol       = '0;
    for (int k = 0; k < 3; k++) begin
      lit[k] = mem_rd_data_i[k*WIDTH +: WIDTH];
      mag[k] = lit[k][WIDTH-1] ? -lit[k] : lit[k];
      eq[k]  = rd_open[k] && (mag[k] == {1'b0, var_q});
      // Literal is made true when its polarity agrees with the assigned value.
      pol[k] = eq[k] && (lit[k][WIDTH-1] ^ val_q);
    end
    hit      = rd_valid && rd_active && (|eq);
    sat      = |pol;
    open_new = sat ? 3'b000 : (rd_open & ~eq);
    open_cnt = {1'b0, open_new[0]} + {1'b0, open_new[1]} + {1'b0, open_new[2]};
    unit_lit = '0;
    if (open_new[0])      unit_lit = lit[0];
    else if (open_new[1]) unit_lit = lit[1];
    else if (open_new[2]) unit_lit = lit[2];
    upd_word = {rd_valid, ~sat, open_new, mem_rd_data_i[3*WIDTH-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      var_q          <= '0;
      val_q          <= 1'b0;
      conflict_q     <= 1'b0;
      start_ready_o  <= 1'b1;
      mem_rd_en_o    <= 1'b0;
      mem_addr_o     <= '0;
      mem_wr_en_o    <= 1'b0;
      mem_wr_data_o  <= '0;
      unit_valid_o   <= 1'b0;
      unit_lit_o     <= '0;
      unit_idx_o     <= '0;
      done_o         <= 1'b0;
      conflict_o     <= 1'b0;
      conflict_idx_o <= '0;
    end else begin
      mem_rd_en_o    <= 1'b0;
      mem_wr_en_o    <= 1'b0;
      done_o         <= 1'b0;
      conflict_o     <= 1'b0;
      conflict_idx_o <= '0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            var_q         <= asg_var_i;
            val_q         <= asg_val_i;
            idx_q         <= '0;
            mem_rd_en_o   <= 1'b1;
            mem_addr_o    <= '0;
            start_ready_o <= 1'b0;
            state_q       <= StRd;
          end
        end
        StRd: state_q <= StEval;
        StEval: begin
          mem_wr_data_o <= upd_word;
          if (!hit) begin
            state_q <= StNext;
          end else if (!sat && open_cnt == 2'd1) begin
            unit_valid_o <= 1'b1;
            unit_lit_o   <= unit_lit;
            unit_idx_o   <= idx_q;
            state_q      <= StEmit;
          end else begin
            conflict_q  <= !sat && (open_cnt == 2'd0);
            mem_wr_en_o <= 1'b1;
            mem_addr_o  <= idx_q;
            state_q     <= StWr;
          end
        end
        StEmit: begin
          if (unit_ready_i) begin
            unit_valid_o <= 1'b0;
            mem_wr_en_o  <= 1'b1;
            mem_addr_o   <= idx_q;
            state_q      <= StWr;
          end
        end
        StWr: begin
          if (conflict_q) begin
            done_o         <= 1'b1;
            conflict_o     <= 1'b1;
            conflict_idx_o <= idx_q;
            state_q        <= StDone;
          end else begin
            state_q <= StNext;
          end
        end
        StNext: begin
          if (idx_q == LastIdx) begin
            done_o  <= 1'b1;
            state_q <= StDone;
          end else begin
            idx_q       <= idx_q + ADDR_W'(1);
            mem_rd_en_o <= 1'b1;
            mem_addr_o  <= idx_q + ADDR_W'(1);
            state_q     <= StRd;
          end
        end
        StDone: begin
          conflict_q    <= 1'b0;
          start_ready_o <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_assign_update.sv
// Directed bench for assign_update with a behavioural single-port clause RAM.
module tb_assign_update;

  localparam int NC = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_ready;
  logic [7:0]  asg_var = '0;
  logic        asg_val = 1'b0;
  logic        mem_rd_en, mem_wr_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] mem_wr_data;
  logic        unit_valid;
  logic        unit_ready = 1'b0;
  logic [8:0]  unit_lit;
  logic [7:0]  unit_idx;
  logic        done, conflict;
  logic [7:0]  conflict_idx;

  int checks = 0;
  int passed = 0;

  // RAM model and bus monitors
  logic [31:0] mem [NC];
  int          rd_cnt [NC];
  int          wr_cnt [NC];
  int          first_rd = -1;
  int          clash = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic        clr = 1'b0;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  assign_update dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .start_ready_o (start_ready),
    .asg_var_i     (asg_var),
    .asg_val_i     (asg_val),
    .mem_rd_en_o   (mem_rd_en),
    .mem_addr_o    (mem_addr),
    .mem_rd_data_i (mem_rd_data),
    .mem_wr_en_o   (mem_wr_en),
    .mem_wr_data_o (mem_wr_data),
    .unit_valid_o  (unit_valid),
    .unit_ready_i  (unit_ready),
    .unit_lit_o    (unit_lit),
    .unit_idx_o    (unit_idx),
    .done_o        (done),
    .conflict_o    (conflict),
    .conflict_idx_o(conflict_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NC; i++) begin
        mem[i] = '0;
        rd_cnt[i] = 0;
        wr_cnt[i] = 0;
      end
      first_rd = -1;
    end else if (ld_en) begin
      mem[ld_addr] = ld_data;
    end else begin
      if (mem_rd_en && mem_wr_en) clash++;
      if (mem_rd_en) begin
        mem_rd_data <= mem[mem_addr];
        rd_cnt[mem_addr]++;
        if (first_rd < 0) first_rd = int'(mem_addr);
      end
      if (mem_wr_en) begin
        mem[mem_addr] = mem_wr_data;
        wr_cnt[mem_addr]++;
      end
    end
    if (unit_valid && unit_ready) hs_cnt++;
  end

  always @(negedge clk) if (done) done_cnt++;

  function automatic logic [31:0] cw(input bit v, input bit a, input logic [2:0] o,
                                     input int l2, input int l1, input int l0);
    logic [8:0] x2, x1, x0;
    x2 = l2[8:0];
    x1 = l1[8:0];
    x0 = l0[8:0];
    return {v, a, o, x2, x1, x0};
  endfunction

  task automatic clear_mem();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk); ld_en = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] v, input bit val);
    @(negedge clk); asg_var = v; asg_val = val; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit got, output logic cf, output logic [7:0] ci);
    got = 1'b0; cf = 1'b0; ci = '0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; cf = conflict; ci = conflict_idx; end
    end
  endtask

  task automatic wait_unit(output bit got);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (unit_valid) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (start_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", start_ready); else passed++;
    checks++; if ({mem_rd_en, mem_wr_en, unit_valid, done, conflict} !== 5'b0)
      $display("FAIL rst_outs: got %b want 00000", {mem_rd_en, mem_wr_en, unit_valid, done, conflict});
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (start_ready !== 1'b1 || mem_rd_en !== 1'b0)
      $display("FAIL rst_idle: got rdy=%b rd=%b want 1/0", start_ready, mem_rd_en);
    else passed++;
  endtask

  task automatic test_clear();
    bit got; logic cf; logic [7:0] ci; int d0;
    clear_mem();
    load(8'd0, cw(1, 1, 3'b111, 5, -3, 2));
    d0 = done_cnt;
    do_start(8'd3, 1'b1);
    wait_done(got, cf, ci);
    checks++; if (!got) $display("FAIL clr_done: got timeout want done"); else passed++;
    checks++; if (mem[0] !== cw(1, 1, 3'b101, 5, -3, 2))
      $display("FAIL clr_word: got %h want %h", mem[0], cw(1, 1, 3'b101, 5, -3, 2));
    else passed++;
    checks++; if (cf !== 1'b0 || hs_cnt !== 0) $display("FAIL clr_flags: got cf=%b hs=%0d want 0/0", cf, hs_cnt);
    else passed++;
    checks++; if (rd_cnt[NC-1] !== 1 || wr_cnt[0] !== 1)
      $display("FAIL clr_sweep: got rd_last=%0d wr0=%0d want 1/1", rd_cnt[NC-1], wr_cnt[0]);
    else passed++;
    @(negedge clk);
    checks++; if (done_cnt - d0 !== 1 || start_ready !== 1'b1)
      $display("FAIL clr_pulse: got pulses=%0d rdy=%b want 1/1", done_cnt - d0, start_ready);
    else passed++;
  endtask

  task automatic test_unit();
    bit got; logic cf; logic [7:0] ci; int h0; bit ok;
    clear_mem();
    load(8'd10, cw(1, 1, 3'b011, 0, 4, -7));
    load(8'd20, cw(1, 1, 3'b111, 7, 1, 2));
    load(8'd40, cw(1, 1, 3'b111, 4, 1, 2));
    h0 = hs_cnt;
    unit_ready = 1'b0;
    do_start(8'd7, 1'b1);
    wait_unit(got);
    checks++; if (!got) $display("FAIL unit_seen: got timeout want unit_valid"); else passed++;
    checks++; if (unit_lit !== 9'h004 || unit_idx !== 8'd10)
      $display("FAIL unit_data: got lit=%h idx=%0d want 004/10", unit_lit, unit_idx);
    else passed++;
    start = 1'b1; asg_var = 8'd4; asg_val = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ok = unit_valid === 1'b1 && unit_lit === 9'h004 && unit_idx === 8'd10 && mem_wr_en === 1'b0;
      checks++; if (!ok) $display("FAIL unit_hold%0d: got v=%b lit=%h idx=%0d wr=%b want 1/004/10/0",
                                 c, unit_valid, unit_lit, unit_idx, mem_wr_en);
      else passed++;
    end
    start = 1'b0;
    checks++; if (start_ready !== 1'b0 || wr_cnt[10] !== 0)
      $display("FAIL unit_busy: got rdy=%b wr10=%0d want 0/0", start_ready, wr_cnt[10]);
    else passed++;
    unit_ready = 1'b1;
    wait_done(got, cf, ci);
    unit_ready = 1'b0;
    checks++; if (!got || cf !== 1'b0) $display("FAIL unit_done: got done=%b cf=%b want 1/0", got, cf);
    else passed++;
    checks++; if (mem[10] !== cw(1, 1, 3'b010, 0, 4, -7) || hs_cnt - h0 !== 1)
      $display("FAIL unit_wb: got %h hs=%0d want %h/1", mem[10], hs_cnt - h0, cw(1, 1, 3'b010, 0, 4, -7));
    else passed++;
    checks++; if (mem[20] !== cw(1, 0, 3'b000, 7, 1, 2) || mem[40] !== cw(1, 1, 3'b111, 4, 1, 2))
      $display("FAIL unit_cont: got m20=%h m40=%h want %h/%h", mem[20], mem[40],
               cw(1, 0, 3'b000, 7, 1, 2), cw(1, 1, 3'b111, 4, 1, 2));
    else passed++;
  endtask

  task automatic test_conflict();
    bit got; logic cf; logic [7:0] ci; int late;
    clear_mem();
    load(8'd5, cw(1, 1, 3'b001, 1, 1, 6));
    load(8'd6, cw(1, 1, 3'b111, 6, 2, 3));
    do_start(8'd6, 1'b0);
    wait_done(got, cf, ci);
    checks++; if (!got || cf !== 1'b1 || ci !== 8'd5)
      $display("FAIL cfl_flag: got done=%b cf=%b idx=%0d want 1/1/5", got, cf, ci);
    else passed++;
    checks++; if (mem[5] !== cw(1, 1, 3'b000, 1, 1, 6))
      $display("FAIL cfl_word: got %h want %h", mem[5], cw(1, 1, 3'b000, 1, 1, 6));
    else passed++;
    late = 0;
    for (int i = 6; i < NC; i++) late += rd_cnt[i];
    checks++; if (late !== 0 || mem[6] !== cw(1, 1, 3'b111, 6, 2, 3))
      $display("FAIL cfl_stop: got late_reads=%0d m6=%h want 0/%h", late, mem[6], cw(1, 1, 3'b111, 6, 2, 3));
    else passed++;
    @(negedge clk);
    checks++; if (conflict !== 1'b0 || done !== 1'b0 || conflict_idx !== 8'd0)
      $display("FAIL cfl_clear: got cf=%b done=%b idx=%0d want 0/0/0", conflict, done, conflict_idx);
    else passed++;
  endtask

  task automatic test_satisfy();
    bit got; logic cf; logic [7:0] ci; int h0;
    clear_mem();
    load(8'd3, cw(1, 1, 3'b110, -9, 9, 2));
    h0 = hs_cnt;
    do_start(8'd9, 1'b0);
    wait_done(got, cf, ci);
    checks++; if (mem[3] !== cw(1, 0, 3'b000, -9, 9, 2))
      $display("FAIL sat_word: got %h want %h", mem[3], cw(1, 0, 3'b000, -9, 9, 2));
    else passed++;
    checks++; if (!got || cf !== 1'b0 || hs_cnt !== h0)
      $display("FAIL sat_flags: got done=%b cf=%b units=%0d want 1/0/0", got, cf, hs_cnt - h0);
    else passed++;
  endtask

  task automatic test_skip();
    bit got; logic cf; logic [7:0] ci; int d0;
    clear_mem();
    load(8'd0, cw(1, 0, 3'b111, 4, 1, 2));
    load(8'd1, cw(0, 1, 3'b111, 4, 1, 2));
    load(8'd255, cw(1, 1, 3'b111, 4, 1, 2));
    d0 = done_cnt;
    do_start(8'd4, 1'b0);
    wait_done(got, cf, ci);
    checks++; if (wr_cnt[0] !== 0 || wr_cnt[1] !== 0)
      $display("FAIL skip_nowr: got wr0=%0d wr1=%0d want 0/0", wr_cnt[0], wr_cnt[1]);
    else passed++;
    checks++; if (mem[255] !== cw(1, 1, 3'b011, 4, 1, 2) || rd_cnt[255] !== 1)
      $display("FAIL skip_last: got %h rd=%0d want %h/1", mem[255], rd_cnt[255], cw(1, 1, 3'b011, 4, 1, 2));
    else passed++;
    repeat (3) @(negedge clk);
    checks++; if (!got || done_cnt - d0 !== 1)
      $display("FAIL skip_pulse: got pulses=%0d want 1", done_cnt - d0);
    else passed++;
  endtask

  task automatic test_reset_emit();
    bit got; logic cf; logic [7:0] ci;
    clear_mem();
    load(8'd30, cw(1, 1, 3'b011, 0, 4, -7));
    unit_ready = 1'b0;
    do_start(8'd7, 1'b1);
    wait_unit(got);
    checks++; if (!got) $display("FAIL remit_unit: got timeout want unit_valid"); else passed++;
    @(negedge clk); rst_n = 1'b0;
    #1;
    checks++; if (unit_valid !== 1'b0 || start_ready !== 1'b1)
      $display("FAIL remit_rst: got v=%b rdy=%b want 0/1", unit_valid, start_ready);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    checks++; if (wr_cnt[30] !== 0) $display("FAIL remit_nowr: got %0d want 0", wr_cnt[30]); else passed++;
    clear_mem();
    load(8'd0, cw(1, 1, 3'b111, 5, -3, 2));
    do_start(8'd3, 1'b1);
    wait_done(got, cf, ci);
    checks++; if (!got || first_rd !== 0 || mem[0] !== cw(1, 1, 3'b101, 5, -3, 2))
      $display("FAIL remit_restart: got first=%0d m0=%h want 0/%h", first_rd, mem[0], cw(1, 1, 3'b101, 5, -3, 2));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clear();
    test_unit();
    test_conflict();
    test_satisfy();
    test_skip();
    test_reset_emit();
    checks++; if (clash !== 0) $display("FAIL rw_clash: got %0d want 0", clash); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
